// File: rtl/thcomp_ctrl_pkg.sv
// Shared constants and state encoding for the threshold-comparator sequencer.
package thcomp_ctrl_pkg;

  localparam int unsigned ThcompMsb      = 15;
  localparam int unsigned ThcompFoundBit = ThcompMsb;
  localparam int unsigned ThcompIdxLsb   = 0;

  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StPeak,
    StReport,
    StHold
  } thcomp_state_e;

endpackage

// File: rtl/thcomp_peak_tracker.sv
// Holds the running peak magnitude and its sample index for the current window.
module thcomp_peak_tracker #(
  parameter int unsigned MagW = 16,
  parameter int unsigned IdxW = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load,
  input  logic            update,
  input  logic [MagW-1:0] mag,
  input  logic [IdxW-1:0] idx,
  output logic [MagW-1:0] peak_mag,
  output logic [IdxW-1:0] peak_idx
);

  logic [MagW-1:0] peak_mag_q, peak_mag_d;
  logic [IdxW-1:0] peak_idx_q, peak_idx_d;

  always_comb begin
    peak_mag_d = peak_mag_q;
    peak_idx_d = peak_idx_q;
    if (clr) begin
      peak_mag_d = '0;
      peak_idx_d = '0;
    end else if (load) begin
      peak_mag_d = mag;
      peak_idx_d = idx;
    end else if (update && (mag > peak_mag_q)) begin
      // Strict compare: a tie keeps the earlier sample.
      peak_mag_d = mag;
      peak_idx_d = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_mag_q <= '0;
      peak_idx_q <= '0;
    end else begin
      peak_mag_q <= peak_mag_d;
      peak_idx_q <= peak_idx_d;
    end
  end

  assign peak_mag = peak_mag_q;
  assign peak_idx = peak_idx_q;

endmodule

// File: rtl/thcomp_ctrl.sv
// Threshold-comparator sequencer: search for a crossing, track the peak over a window,
// write the result word to THCOMPREG, then blank for a holdoff period.
module thcomp_ctrl
  import thcomp_ctrl_pkg::*;
#(
  parameter int unsigned MSB     = ThcompMsb,
  parameter int unsigned IDX_W   = 12,
  parameter int unsigned WINDOW  = 16,
  parameter int unsigned HOLDOFF = 64,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [MSB:0] threshold,
  input  logic         corr_valid,
  input  logic [MSB:0] corr_mag,
  output logic         thcomp_we0,
  output logic [MSB:0] thcomp_reg_data_in0,
  output logic         thcomp_busy,
  output logic         thcomp_sync_found,
  output logic [MSB:0] thcomp_peak_mag
);

  if (IDX_W > MSB) begin : g_bad_idx_w
    $error("thcomp_ctrl: IDX_W must not exceed MSB");
  end

  localparam int unsigned WinW  = $clog2(WINDOW + 1);
  localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [IDX_W-1:0] IdxTimeout = IDX_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IdxMax     = '1;
  localparam logic [WinW-1:0]  WinLast    = WinW'(WINDOW);
  localparam logic [HoldW-1:0] HoldLast   = HoldW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  thcomp_state_e    state_q, state_d;
  logic [MSB:0]     thr_lat_q, thr_lat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WinW-1:0]  win_cnt_q, win_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             found_q, found_d;
  logic [MSB:0]     peak_out_q, peak_out_d;

  logic             trk_clr, trk_load, trk_update;
  logic [MSB:0]     trk_peak_mag;
  logic [IDX_W-1:0] trk_peak_idx;

  thcomp_peak_tracker #(
    .MagW (MSB + 1),
    .IdxW (IDX_W)
  ) u_peak_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (trk_clr),
    .load     (trk_load),
    .update   (trk_update),
    .mag      (corr_mag),
    .idx      (idx_q),
    .peak_mag (trk_peak_mag),
    .peak_idx (trk_peak_idx)
  );

  always_comb begin
    state_d             = state_q;
    thr_lat_d           = thr_lat_q;
    idx_d               = idx_q;
    win_cnt_d           = win_cnt_q;
    hold_cnt_d          = hold_cnt_q;
    found_d             = found_q;
    peak_out_d          = peak_out_q;
    trk_clr             = 1'b0;
    trk_load            = 1'b0;
    trk_update          = 1'b0;
    thcomp_we0          = 1'b0;
    thcomp_reg_data_in0 = '0;
    thcomp_sync_found   = 1'b0;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StSearch;
            thr_lat_d  = threshold;
            idx_d      = '0;
            win_cnt_d  = '0;
            hold_cnt_d = '0;
            found_d    = 1'b0;
            trk_clr    = 1'b1;
          end
        end
        StSearch: begin
          if (corr_valid) begin
            if (corr_mag > thr_lat_q) begin
              // idx tracks the index of the next sample; TIMEOUT keeps this from wrapping.
              trk_load  = 1'b1;
              idx_d     = idx_q + 1'b1;
              win_cnt_d = WinW'(1);
              found_d   = 1'b1;
              state_d   = (WINDOW == 1) ? StReport : StPeak;
            end else if (idx_q == IdxTimeout) begin
              found_d = 1'b0;
              state_d = StReport;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        StPeak: begin
          if (corr_valid) begin
            trk_update = 1'b1;
            idx_d      = (idx_q == IdxMax) ? idx_q : idx_q + 1'b1;
            win_cnt_d  = win_cnt_q + 1'b1;
            if (win_cnt_d == WinLast) begin
              state_d = StReport;
            end
          end
        end
        StReport: begin
          thcomp_we0               = 1'b1;
          thcomp_reg_data_in0[MSB] = found_q;
          if (found_q) begin
            thcomp_reg_data_in0[ThcompIdxLsb +: IDX_W] = trk_peak_idx;
            thcomp_sync_found = 1'b1;
            peak_out_d        = trk_peak_mag;
            hold_cnt_d        = '0;
            state_d           = (HOLDOFF == 0) ? StIdle : StHold;
          end else begin
            state_d = StIdle;
          end
        end
        StHold: begin
          if (corr_valid) begin
            if (hold_cnt_q == HoldLast) begin
              hold_cnt_d = '0;
              state_d    = StIdle;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      thr_lat_q  <= '0;
      idx_q      <= '0;
      win_cnt_q  <= '0;
      hold_cnt_q <= '0;
      found_q    <= 1'b0;
      peak_out_q <= '0;
    end else begin
      state_q    <= state_d;
      thr_lat_q  <= thr_lat_d;
      idx_q      <= idx_d;
      win_cnt_q  <= win_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      found_q    <= found_d;
      peak_out_q <= peak_out_d;
    end
  end

  assign thcomp_busy     = (state_q != StIdle);
  assign thcomp_peak_mag = peak_out_q;

endmodule

// File: tb/tb_thcomp_ctrl.sv
// Directed bench for thcomp_ctrl with a sample-history reference model checked every cycle.
module tb_thcomp_ctrl;

  localparam int unsigned Win  = 4;
  localparam int unsigned Hold = 64;
  localparam int unsigned Tmo  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] threshold;
  logic        corr_valid;
  logic [15:0] corr_mag;
  logic        thcomp_we0;
  logic [15:0] thcomp_reg_data_in0;
  logic        thcomp_busy;
  logic        thcomp_sync_found;
  logic [15:0] thcomp_peak_mag;

  thcomp_ctrl #(
    .MSB     (15),
    .IDX_W   (12),
    .WINDOW  (Win),
    .HOLDOFF (Hold),
    .TIMEOUT (Tmo)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .abort               (abort),
    .threshold           (threshold),
    .corr_valid          (corr_valid),
    .corr_mag            (corr_mag),
    .thcomp_we0          (thcomp_we0),
    .thcomp_reg_data_in0 (thcomp_reg_data_in0),
    .thcomp_busy         (thcomp_busy),
    .thcomp_sync_found   (thcomp_sync_found),
    .thcomp_peak_mag     (thcomp_peak_mag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the magnitudes seen since start and decides from that history.
  bit          m_init = 0;
  bit          m_armed = 0;
  bit          m_report = 0;
  bit          m_rep_found = 0;
  int unsigned m_rep_idx = 0;
  int unsigned m_rep_mag = 0;
  int unsigned m_hold_left = 0;
  int unsigned m_peak_out = 0;
  int unsigned m_thr = 0;
  int unsigned m_run[$];

  int          wr_count = 0;
  int          sf_count = 0;
  logic [15:0] last_wr = '0;

  always @(negedge clk) begin : model
    bit exp_wr;
    int first;
    int best;
    if (m_init) begin
      exp_wr = m_report && !abort;
      chk("busy", 32'(thcomp_busy), 32'(m_armed || m_report || (m_hold_left != 0)));
      chk("we0", 32'(thcomp_we0), 32'(exp_wr));
      chk("sync_found", 32'(thcomp_sync_found), 32'(exp_wr && m_rep_found));
      chk("peak_mag", 32'(thcomp_peak_mag), m_peak_out);
      if (exp_wr) begin
        chk("wr_data", 32'(thcomp_reg_data_in0), m_rep_found ? (32'h8000 | m_rep_idx) : 32'h0);
      end
      if (thcomp_we0 === 1'b1) begin
        wr_count++;
        last_wr = thcomp_reg_data_in0;
      end
      if (thcomp_sync_found === 1'b1) sf_count++;
    end

    if (!rst_n) begin
      m_armed     = 0;
      m_report    = 0;
      m_hold_left = 0;
      m_peak_out  = 0;
      m_run.delete();
      m_init      = 1;
    end else if (abort) begin
      m_armed     = 0;
      m_report    = 0;
      m_hold_left = 0;
    end else if (m_report) begin
      m_report = 0;
      if (m_rep_found) begin
        m_peak_out  = m_rep_mag;
        m_hold_left = Hold;
      end
    end else if (m_hold_left != 0) begin
      if (corr_valid) m_hold_left--;
    end else if (m_armed) begin
      if (corr_valid) begin
        m_run.push_back(32'(corr_mag));
        first = -1;
        foreach (m_run[i]) if (first < 0 && m_run[i] > m_thr) first = i;
        if (first >= 0 && (m_run.size() - first) == Win) begin
          best = first;
          for (int i = first + 1; i < first + int'(Win); i++) if (m_run[i] > m_run[best]) best = i;
          m_report    = 1;
          m_rep_found = 1;
          m_rep_idx   = best;
          m_rep_mag   = m_run[best];
          m_armed     = 0;
        end else if (first < 0 && m_run.size() == Tmo) begin
          m_report    = 1;
          m_rep_found = 0;
          m_armed     = 0;
        end
      end
    end else if (start) begin
      m_armed = 1;
      m_thr   = threshold;
      m_run.delete();
    end
  end

  task automatic cyc(input logic st, input logic ab, input logic v, input logic [15:0] mag);
    start      = st;
    abort      = ab;
    corr_valid = v;
    corr_mag   = mag;
    @(posedge clk);
    #1;
    start      = 1'b0;
    abort      = 1'b0;
    corr_valid = 1'b0;
  endtask

  task automatic run_seq(input logic [15:0] thr_v, input int unsigned mags[$], input int gap);
    threshold = thr_v;
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    foreach (mags[i]) begin
      repeat (gap) cyc(1'b0, 1'b0, 1'b0, 16'd0);
      cyc(1'b0, 1'b0, 1'b1, 16'(mags[i]));
    end
  endtask

  // Leave REPORT, then feed the full holdoff of valid samples.
  task automatic drain_hold();
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    repeat (Hold) cyc(1'b0, 1'b0, 1'b1, 16'd0);
    chk("drain_idle", 32'(thcomp_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int unsigned q[$];
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    threshold  = 16'd0;
    corr_valid = 1'b0;
    corr_mag   = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_busy", 32'(thcomp_busy), 32'd0);
    chk("rst_we0", 32'(thcomp_we0), 32'd0);
    chk("rst_peak", 32'(thcomp_peak_mag), 32'd0);

    // Crossing at idx 2, peak 200 at idx 3, window of 4 samples.
    q = '{10, 50, 120, 200, 150, 30};
    run_seq(16'd100, q, 0);
    chk("t1_we0", 32'(thcomp_we0), 32'd1);
    chk("t1_data", 32'(thcomp_reg_data_in0), 32'h8003);
    chk("t1_sf", 32'(thcomp_sync_found), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("t1_peak", 32'(thcomp_peak_mag), 32'd200);
    chk("t1_hold_busy", 32'(thcomp_busy), 32'd1);

    // Holdoff with stray start pulses.
    for (int i = 0; i < int'(Hold); i++) begin
      if (i % 10 == 3) cyc(1'b1, 1'b0, 1'b0, 16'd0);
      cyc(1'b0, 1'b0, 1'b1, 16'd999);
      if (i == int'(Hold) - 2) chk("t5_busy_63", 32'(thcomp_busy), 32'd1);
    end
    chk("t5_busy_64", 32'(thcomp_busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("t5_no_rearm", 32'(thcomp_busy), 32'd0);

    // All-ones threshold never hits: timeout after 8 samples.
    q = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_seq(16'hFFFF, q, 1);
    chk("t2_we0", 32'(thcomp_we0), 32'd1);
    chk("t2_data", 32'(thcomp_reg_data_in0), 32'h0000);
    chk("t2_sf", 32'(thcomp_sync_found), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("t2_idle", 32'(thcomp_busy), 32'd0);
    chk("t2_peak", 32'(thcomp_peak_mag), 32'd200);

    // Equal peaks at idx 5 and 7: earlier wins, with and without gaps.
    q = '{10, 20, 30, 40, 50, 300, 100, 300, 250};
    run_seq(16'd200, q, 0);
    chk("t3_data", 32'(thcomp_reg_data_in0), 32'h8005);
    drain_hold();
    run_seq(16'd200, q, 3);
    chk("t3_gap_data", 32'(thcomp_reg_data_in0), 32'h8005);
    chk("t3_gap_we0", 32'(thcomp_we0), 32'd1);
    drain_hold();
    chk("t3_peak", 32'(thcomp_peak_mag), 32'd300);

    // Abort in PEAK, then a clean search from idx 0.
    q = '{10, 150, 160};
    run_seq(16'd100, q, 0);
    cyc(1'b0, 1'b1, 1'b1, 16'd500);
    chk("t4_busy", 32'(thcomp_busy), 32'd0);
    chk("t4_we0", 32'(thcomp_we0), 32'd0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 16'd900);
    chk("t4_no_wr", 32'(wr_count), 32'd4);
    q = '{200, 1, 2, 3};
    run_seq(16'd100, q, 0);
    chk("t4_data", 32'(thcomp_reg_data_in0), 32'h8000);
    drain_hold();

    // Abort together with start stays idle.
    cyc(1'b1, 1'b1, 1'b0, 16'd0);
    chk("abort_start", 32'(thcomp_busy), 32'd0);

    // Threshold change mid-search is ignored.
    threshold = 16'd100;
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'd50);
    threshold = 16'd10;
    q = '{60, 90, 101, 0, 0, 0};
    foreach (q[i]) cyc(1'b0, 1'b0, 1'b1, 16'(q[i]));
    chk("t6_data", 32'(thcomp_reg_data_in0), 32'h8003);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("t6_peak", 32'(thcomp_peak_mag), 32'd101);
    repeat (Hold) cyc(1'b0, 1'b0, 1'b1, 16'd0);

    // Reset mid-PEAK clears everything.
    q = '{150};
    run_seq(16'd100, q, 0);
    chk("t6_in_peak", 32'(thcomp_busy), 32'd1);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("rst2_busy", 32'(thcomp_busy), 32'd0);
    chk("rst2_we0", 32'(thcomp_we0), 32'd0);
    chk("rst2_sf", 32'(thcomp_sync_found), 32'd0);
    chk("rst2_peak", 32'(thcomp_peak_mag), 32'd0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 16'd0);

    chk("wr_total", 32'(wr_count), 32'd6);
    chk("sf_total", 32'(sf_count), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
